// File: rtl/spi_model_pkg.sv
// Shared command codes, FSM states and lane-direction patterns for the
// system-clocked SPI flash model.
package spi_model_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_FREAD = 8'h0B;
    localparam logic [7:0] CMD_QREAD = 8'h6B;
    localparam logic [7:0] CMD_PP    = 8'h02;
    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_WRDI  = 8'h04;
    localparam logic [7:0] CMD_RDSR  = 8'h05;

    localparam logic [3:0] DQT_SINGLE = 4'b1101;
    localparam logic [3:0] DQT_QUAD   = 4'b0000;
    localparam logic [3:0] DQT_OFF    = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RD_OUT,
        WR_IN,
        STATUS,
        IGNORE
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with single-clk rise/fall pulses derived from the
// synchronised level.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
            prev <= q;
        end
    end

    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_flash_model_mc.sv
// Multi-command SPI flash model running on the system clock: oversamples the
// SPI pins, decodes read/fast/quad read, page program, WREN/WRDI and RDSR.
module spi_flash_model_mc
    import spi_model_pkg::*;
#(
    parameter int SIZE         = 2**13,
    parameter int ADDR_BYTES   = 3,
    parameter int DUMMY_CYCLES = 8,
    parameter int PAGE         = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sck,
    input  logic                    cs_n,
    input  logic [3:0]              dq_i,
    output logic [3:0]              dq_o,
    output logic [3:0]              dq_t,
    input  logic                    bd_we,
    input  logic [$clog2(SIZE)-1:0] bd_addr,
    input  logic [7:0]              bd_wdata,
    output logic [7:0]              bd_rdata,
    output logic                    wel_o
);

    localparam int AW    = $clog2(SIZE);
    localparam int ABITS = 8 * ADDR_BYTES;
    localparam logic [5:0]    ADDR_LAST  = 6'(ABITS - 1);
    localparam logic [7:0]    DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
    localparam logic [AW-1:0] PAGE_MASK  = AW'(PAGE - 1);

    logic [7:0] mem [SIZE];

    logic sck_level_unused, sck_rise, sck_fall;
    logic cs_s, cs_rise_unused, cs_fall_unused;
    logic [3:0] dq_meta, dq_s;
    logic dq_unused;

    spi_state_e state, state_d;
    logic [7:0]    cmd, cmd_d;
    logic [5:0]    bit_cnt, bit_cnt_d;
    logic [7:0]    dummy_cnt, dummy_cnt_d;
    logic [AW-1:0] addr, addr_d;
    logic [7:0]    shift, shift_d;
    logic          wel, wel_d;
    logic [3:0]    dq_o_d;
    logic          wr_pend, wr_pend_d;
    logic [AW-1:0] wr_addr, wr_addr_d;
    logic [7:0]    wr_data, wr_data_d;

    logic [7:0]    cmd_shift, byte_shift, rd_byte, status_byte;
    logic [2:0]    bit_sel;
    logic [AW-1:0] page_next;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sck),
        .q    (sck_level_unused),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (cs_n),
        .q    (cs_s),
        .rise (cs_rise_unused),
        .fall (cs_fall_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dq_meta <= '0;
            dq_s    <= '0;
        end else begin
            dq_meta <= dq_i;
            dq_s    <= dq_meta;
        end
    end

    // Only lane 0 carries host data in; the upper lanes are synchronised but unused.
    assign dq_unused   = ^dq_s[3:1];
    assign cmd_shift   = {cmd[6:0], dq_s[0]};
    assign byte_shift  = {shift[6:0], dq_s[0]};
    assign rd_byte     = mem[addr];
    assign status_byte = {6'b0, wel, 1'b0};
    assign bit_sel     = 3'd7 - bit_cnt[2:0];
    assign page_next   = (addr & ~PAGE_MASK) | ((addr + 1'b1) & PAGE_MASK);
    assign bd_rdata    = mem[bd_addr];
    assign wel_o       = wel;

    always_comb begin
        dq_t = DQT_OFF;
        if (state == RD_OUT) begin
            dq_t = (cmd == CMD_QREAD) ? DQT_QUAD : DQT_SINGLE;
        end else if (state == STATUS) begin
            dq_t = DQT_SINGLE;
        end
    end

    always_comb begin
        state_d     = state;
        cmd_d       = cmd;
        bit_cnt_d   = bit_cnt;
        dummy_cnt_d = dummy_cnt;
        addr_d      = addr;
        shift_d     = shift;
        wel_d       = wel;
        dq_o_d      = dq_o;
        wr_pend_d   = 1'b0;
        wr_addr_d   = wr_addr;
        wr_data_d   = wr_data;

        if (cs_s) begin
            // Deselect aborts everything; a program that reached its data phase drops WEL.
            state_d     = IDLE;
            bit_cnt_d   = '0;
            dummy_cnt_d = '0;
            shift_d     = '0;
            if (state == WR_IN) begin
                wel_d = 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                end
                CMD: begin
                    if (sck_rise) begin
                        cmd_d = cmd_shift;
                        if (bit_cnt == 6'd7) begin
                            bit_cnt_d = '0;
                            case (cmd_shift)
                                CMD_READ, CMD_FREAD, CMD_QREAD, CMD_PP: state_d = ADDR;
                                CMD_RDSR: state_d = STATUS;
                                CMD_WREN: begin
                                    wel_d   = 1'b1;
                                    state_d = IGNORE;
                                end
                                CMD_WRDI: begin
                                    wel_d   = 1'b0;
                                    state_d = IGNORE;
                                end
                                default:  state_d = IGNORE;
                            endcase
                        end else begin
                            bit_cnt_d = bit_cnt + 6'd1;
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        addr_d = {addr[AW-2:0], dq_s[0]};
                        if (bit_cnt == ADDR_LAST) begin
                            bit_cnt_d   = '0;
                            dummy_cnt_d = '0;
                            case (cmd)
                                CMD_READ:             state_d = RD_OUT;
                                CMD_FREAD, CMD_QREAD: state_d = (DUMMY_CYCLES == 0) ? RD_OUT : DUMMY;
                                CMD_PP:               state_d = wel ? WR_IN : IGNORE;
                                default:              state_d = IGNORE;
                            endcase
                        end else begin
                            bit_cnt_d = bit_cnt + 6'd1;
                        end
                    end
                end
                DUMMY: begin
                    if (sck_rise) begin
                        if (dummy_cnt == DUMMY_LAST) begin
                            dummy_cnt_d = '0;
                            state_d     = RD_OUT;
                        end else begin
                            dummy_cnt_d = dummy_cnt + 8'd1;
                        end
                    end
                end
                RD_OUT: begin
                    // Falls drive the bit/nibble selected by the count the previous rise left behind.
                    if (sck_fall) begin
                        if (cmd == CMD_QREAD) begin
                            dq_o_d = bit_cnt[0] ? rd_byte[3:0] : rd_byte[7:4];
                        end else begin
                            dq_o_d = {2'b00, rd_byte[bit_sel], 1'b0};
                        end
                    end
                    if (sck_rise) begin
                        if ((cmd == CMD_QREAD) ? bit_cnt[0] : (bit_cnt == 6'd7)) begin
                            bit_cnt_d = '0;
                            addr_d    = addr + 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt + 6'd1;
                        end
                    end
                end
                STATUS: begin
                    if (sck_fall) begin
                        dq_o_d = {2'b00, status_byte[bit_sel], 1'b0};
                    end
                    if (sck_rise) begin
                        bit_cnt_d = (bit_cnt == 6'd7) ? 6'd0 : bit_cnt + 6'd1;
                    end
                end
                WR_IN: begin
                    if (sck_rise) begin
                        shift_d = byte_shift;
                        if (bit_cnt == 6'd7) begin
                            bit_cnt_d = '0;
                            wr_pend_d = 1'b1;
                            wr_addr_d = addr;
                            wr_data_d = byte_shift;
                            addr_d    = page_next;
                        end else begin
                            bit_cnt_d = bit_cnt + 6'd1;
                        end
                    end
                end
                IGNORE: begin
                    state_d = IGNORE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd       <= '0;
            bit_cnt   <= '0;
            dummy_cnt <= '0;
            addr      <= '0;
            shift     <= '0;
            wel       <= 1'b0;
            dq_o      <= '0;
            wr_pend   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state     <= state_d;
            cmd       <= cmd_d;
            bit_cnt   <= bit_cnt_d;
            dummy_cnt <= dummy_cnt_d;
            addr      <= addr_d;
            shift     <= shift_d;
            wel       <= wel_d;
            dq_o      <= dq_o_d;
            wr_pend   <= wr_pend_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
        end
    end

    // Memory is never reset; a backdoor write to the same byte overrides a program commit.
    always_ff @(posedge clk) begin
        if (wr_pend && !(bd_we && bd_addr == wr_addr)) begin
            mem[wr_addr] <= wr_data;
        end
        if (bd_we) begin
            mem[bd_addr] <= bd_wdata;
        end
    end

endmodule

// File: tb/tb_spi_flash_model_mc.sv
// Directed bench for spi_flash_model_mc: acts as an SPI mode-0 host with an
// sck half period of five system clocks and checks against hand-computed bytes.
module tb_spi_flash_model_mc;

    localparam int HALF = 5;

    logic        clk;
    logic        rst;
    logic        sck;
    logic        cs_n;
    logic [3:0]  dq_i;
    logic [3:0]  dq_o;
    logic [3:0]  dq_t;
    logic        bd_we;
    logic [12:0] bd_addr;
    logic [7:0]  bd_wdata;
    logic [7:0]  bd_rdata;
    logic        wel_o;

    int errors = 0;
    int checks = 0;
    logic [3:0] smp_o;
    logic [3:0] smp_t;

    spi_flash_model_mc dut (
        .clk      (clk),
        .rst      (rst),
        .sck      (sck),
        .cs_n     (cs_n),
        .dq_i     (dq_i),
        .dq_o     (dq_o),
        .dq_t     (dq_t),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata),
        .bd_rdata (bd_rdata),
        .wel_o    (wel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b);
        dq_i[0] = b;
        wait_clk(HALF);
        smp_o = dq_o;
        smp_t = dq_t;
        sck = 1'b1;
        wait_clk(HALF);
        sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) spi_bit(v[i]);
    endtask

    task automatic send_addr(input logic [23:0] a);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic send_dummy();
        for (int i = 0; i < 8; i++) spi_bit(1'b0);
    endtask

    task automatic read_single(output logic [7:0] v, output logic [3:0] t);
        v = '0;
        for (int i = 0; i < 8; i++) begin
            spi_bit(1'b0);
            v = {v[6:0], smp_o[1]};
        end
        t = smp_t;
    endtask

    task automatic read_quad(output logic [7:0] v, output logic [3:0] t);
        spi_bit(1'b0);
        v[7:4] = smp_o;
        spi_bit(1'b0);
        v[3:0] = smp_o;
        t = smp_t;
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_end();
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(6);
    endtask

    task automatic simple_cmd(input logic [7:0] c);
        cs_begin();
        send_byte(c);
        cs_end();
    endtask

    task automatic bd_write(input logic [12:0] a, input logic [7:0] d);
        bd_addr  = a;
        bd_wdata = d;
        bd_we    = 1'b1;
        wait_clk(1);
        bd_we    = 1'b0;
    endtask

    task automatic peek(input logic [12:0] a);
        bd_addr = a;
        wait_clk(1);
    endtask

    task automatic test_reset();
        wait_clk(3);
        checks++;
        if (dq_t !== 4'b1111) begin errors++; $display("[TB] FAIL reset_dq_t: got %b expected %b", dq_t, 4'b1111); end
        checks++;
        if (dq_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_dq_o: got %b expected %b", dq_o, 4'b0000); end
        checks++;
        if (wel_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_wel: got %b expected %b", wel_o, 1'b0); end
        rst = 1'b0;
        wait_clk(4);
        checks++;
        if (dq_t !== 4'b1111) begin errors++; $display("[TB] FAIL idle_dq_t: got %b expected %b", dq_t, 4'b1111); end
    endtask

    task automatic test_read();
        logic [7:0] exp_b [3];
        logic [7:0] v;
        logic [3:0] t;
        exp_b = '{8'hA5, 8'h5A, 8'h3C};
        for (int i = 0; i < 3; i++) bd_write(13'h10 + 13'(i), exp_b[i]);
        peek(13'h10);
        checks++;
        if (bd_rdata !== 8'hA5) begin errors++; $display("[TB] FAIL bd_rdata_10: got %h expected %h", bd_rdata, 8'hA5); end
        cs_begin();
        send_byte(8'h03);
        send_addr(24'h000010);
        for (int i = 0; i < 3; i++) begin
            read_single(v, t);
            checks++;
            if (v !== exp_b[i]) begin errors++; $display("[TB] FAIL read_byte%0d: got %h expected %h", i, v, exp_b[i]); end
            checks++;
            if (t !== 4'b1101) begin errors++; $display("[TB] FAIL read_dq_t%0d: got %b expected %b", i, t, 4'b1101); end
        end
        cs_end();
        checks++;
        if (dq_t !== 4'b1111) begin errors++; $display("[TB] FAIL read_end_dq_t: got %b expected %b", dq_t, 4'b1111); end
    endtask

    task automatic test_fast_read_wrap();
        logic [7:0] v;
        logic [3:0] t;
        bd_write(13'h1FFF, 8'h11);
        bd_write(13'h0000, 8'h22);
        cs_begin();
        send_byte(8'h0B);
        send_addr(24'h001FFF);
        send_dummy();
        read_single(v, t);
        checks++;
        if (v !== 8'h11) begin errors++; $display("[TB] FAIL fread_last: got %h expected %h", v, 8'h11); end
        read_single(v, t);
        checks++;
        if (v !== 8'h22) begin errors++; $display("[TB] FAIL fread_wrap: got %h expected %h", v, 8'h22); end
        cs_end();
    endtask

    task automatic test_quad_read();
        logic [7:0] exp_b [3];
        logic [7:0] v;
        logic [3:0] t;
        exp_b = '{8'hA5, 8'h5A, 8'h3C};
        cs_begin();
        send_byte(8'h6B);
        send_addr(24'h000010);
        send_dummy();
        for (int i = 0; i < 3; i++) begin
            read_quad(v, t);
            checks++;
            if (v !== exp_b[i]) begin errors++; $display("[TB] FAIL qread_byte%0d: got %h expected %h", i, v, exp_b[i]); end
            checks++;
            if (t !== 4'b0000) begin errors++; $display("[TB] FAIL qread_dq_t%0d: got %b expected %b", i, t, 4'b0000); end
        end
        cs_end();
    endtask

    task automatic test_page_program();
        bd_write(13'h0020, 8'h99);
        cs_begin();
        send_byte(8'h02);
        send_addr(24'h000020);
        send_byte(8'h77);
        cs_end();
        peek(13'h0020);
        checks++;
        if (bd_rdata !== 8'h99) begin errors++; $display("[TB] FAIL pp_no_wel_mem: got %h expected %h", bd_rdata, 8'h99); end
        checks++;
        if (wel_o !== 1'b0) begin errors++; $display("[TB] FAIL pp_no_wel_wel: got %b expected %b", wel_o, 1'b0); end
        simple_cmd(8'h06);
        checks++;
        if (wel_o !== 1'b1) begin errors++; $display("[TB] FAIL wren: got %b expected %b", wel_o, 1'b1); end
        cs_begin();
        send_byte(8'h02);
        send_addr(24'h0000FF);
        send_byte(8'h01);
        send_byte(8'h02);
        cs_end();
        checks++;
        if (wel_o !== 1'b0) begin errors++; $display("[TB] FAIL pp_wel_clear: got %b expected %b", wel_o, 1'b0); end
        peek(13'h00FF);
        checks++;
        if (bd_rdata !== 8'h01) begin errors++; $display("[TB] FAIL pp_mem_ff: got %h expected %h", bd_rdata, 8'h01); end
        peek(13'h0000);
        checks++;
        if (bd_rdata !== 8'h02) begin errors++; $display("[TB] FAIL pp_mem_00_wrap: got %h expected %h", bd_rdata, 8'h02); end
        peek(13'h0100);
        checks++;
        if (bd_rdata === 8'h02) begin errors++; $display("[TB] FAIL pp_no_page_cross: got %h expected not %h", bd_rdata, 8'h02); end
    endtask

    task automatic test_status();
        logic [7:0] v;
        logic [3:0] t;
        simple_cmd(8'h06);
        cs_begin();
        send_byte(8'h05);
        for (int i = 0; i < 2; i++) begin
            read_single(v, t);
            checks++;
            if (v !== 8'h02) begin errors++; $display("[TB] FAIL rdsr_wel%0d: got %h expected %h", i, v, 8'h02); end
        end
        cs_end();
        simple_cmd(8'h04);
        checks++;
        if (wel_o !== 1'b0) begin errors++; $display("[TB] FAIL wrdi: got %b expected %b", wel_o, 1'b0); end
        cs_begin();
        send_byte(8'h05);
        read_single(v, t);
        checks++;
        if (v !== 8'h00) begin errors++; $display("[TB] FAIL rdsr_clear: got %h expected %h", v, 8'h00); end
        cs_end();
    endtask

    task automatic test_back_to_back_partial();
        logic [7:0] v;
        logic [3:0] t;
        cs_begin();
        for (int i = 0; i < 3; i++) spi_bit(1'b0);
        cs_end();
        cs_begin();
        send_byte(8'h03);
        send_addr(24'h000010);
        read_single(v, t);
        checks++;
        if (v !== 8'hA5) begin errors++; $display("[TB] FAIL partial_then_read: got %h expected %h", v, 8'hA5); end
        cs_end();
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] v;
        logic [3:0] t;
        simple_cmd(8'h06);
        cs_begin();
        send_byte(8'h03);
        send_addr(24'h000010);
        read_single(v, t);
        checks++;
        if (v !== 8'hA5) begin errors++; $display("[TB] FAIL mid_read_byte: got %h expected %h", v, 8'hA5); end
        spi_bit(1'b0);
        wait_clk(4);
        checks++;
        if (dq_o !== 4'b0010) begin errors++; $display("[TB] FAIL pre_rst_dq_o: got %b expected %b", dq_o, 4'b0010); end
        checks++;
        if (wel_o !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_wel: got %b expected %b", wel_o, 1'b1); end
        rst = 1'b1;
        wait_clk(1);
        checks++;
        if (dq_t !== 4'b1111) begin errors++; $display("[TB] FAIL rst_mid_dq_t: got %b expected %b", dq_t, 4'b1111); end
        checks++;
        if (dq_o !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mid_dq_o: got %b expected %b", dq_o, 4'b0000); end
        checks++;
        if (wel_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_wel: got %b expected %b", wel_o, 1'b0); end
        cs_n = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(4);
        peek(13'h0010);
        checks++;
        if (bd_rdata !== 8'hA5) begin errors++; $display("[TB] FAIL rst_mem_kept: got %h expected %h", bd_rdata, 8'hA5); end
    endtask

    initial begin
        rst      = 1'b1;
        sck      = 1'b0;
        cs_n     = 1'b1;
        dq_i     = 4'b0000;
        bd_we    = 1'b0;
        bd_addr  = '0;
        bd_wdata = '0;
        smp_o    = '0;
        smp_t    = '0;
        test_reset();
        test_read();
        test_fast_read_wrap();
        test_quad_read();
        test_page_program();
        test_status();
        test_back_to_back_partial();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
